// File: rtl/operand_fwd_if.sv
// Operand-forwarding bus: ID-stage source/destination info, GPR read data,
// writeback port and the resolved EXE-stage operands.
// master = pipeline/environment side, slave = operand_fwd.
interface operand_fwd_if #(
  parameter int DW = 64,
  parameter int AW = 5
);
  logic          id_freeze;
  logic          ex_freeze;
  logic          flushpipe;
  logic          id_valid;
  logic [AW-1:0] id_addra;
  logic [AW-1:0] id_addrb;
  logic          id_rda;
  logic          id_rdb;
  logic [AW-1:0] id_wr_addr;
  logic          id_we;
  logic          id_is_load;
  logic [DW-1:0] rf_dataa;
  logic [DW-1:0] rf_datab;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          wb_we;
  logic [DW-1:0] ex_opa;
  logic [DW-1:0] ex_opb;
  logic          ex_valid;
  logic          hazard_stall;

  modport master (
    output id_freeze, ex_freeze, flushpipe, id_valid, id_addra, id_addrb,
           id_rda, id_rdb, id_wr_addr, id_we, id_is_load, rf_dataa, rf_datab,
           wb_addr, wb_data, wb_we,
    input  ex_opa, ex_opb, ex_valid, hazard_stall
  );

  modport slave (
    input  id_freeze, ex_freeze, flushpipe, id_valid, id_addra, id_addrb,
           id_rda, id_rdb, id_wr_addr, id_we, id_is_load, rf_dataa, rf_datab,
           wb_addr, wb_data, wb_we,
    output ex_opa, ex_opb, ex_valid, hazard_stall
  );
endinterface

// File: rtl/operand_fwd.sv
// EXE-stage operand resolution with writeback / last-write forwarding,
// freeze hold registers and load-use hazard detection.
// Optional feature macro: PIPPO_OPERAND_FWD_EN. When undefined, operands come
// only from the hold register or GPR read data and every RAW against a valid
// writing EXE instruction stalls ID.

// One source operand (a or b): select + freeze hold register.
module operand_fwd_src #(
  parameter int DW = 64,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flushpipe,
  input  logic          ex_freeze,
  input  logic [AW-1:0] addr,
  input  logic          rd,
  input  logic [DW-1:0] rf_data,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          lw_vld,
  input  logic [AW-1:0] lw_addr,
  input  logic [DW-1:0] lw_data,
  output logic [DW-1:0] op
);
  logic          hold_vld;
  logic [DW-1:0] hold_q;
  logic [DW-1:0] sel;

`ifndef PIPPO_OPERAND_FWD_EN
  logic unused_fwd;
  assign unused_fwd = ^{wb_we, wb_addr, wb_data, lw_vld, lw_addr, lw_data};
`endif

  // Priority select: hold > (fwd: wb > last-write) > GPR; r0 never forwarded.
  always_comb begin
    sel = rf_data;
`ifdef PIPPO_OPERAND_FWD_EN
    if (addr != '0) begin
      if (wb_we && (wb_addr == addr))       sel = wb_data;
      else if (lw_vld && (lw_addr == addr)) sel = lw_data;
    end
`endif
    if (hold_vld) sel = hold_q;
    op = rd ? sel : '0;
  end

  // Capture the operand on the first frozen edge, release on first unfrozen edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_vld <= 1'b0;
      hold_q   <= '0;
    end else if (flushpipe) begin
      hold_vld <= 1'b0;
    end else if (ex_freeze && !hold_vld) begin
      hold_vld <= 1'b1;
      hold_q   <= op;
    end else if (!ex_freeze) begin
      hold_vld <= 1'b0;
    end
  end
endmodule

module operand_fwd #(
  parameter int DW = 64,
  parameter int AW = 5
) (
  input  logic      clk,
  input  logic      rst,
  operand_fwd_if.slave bus
);
  localparam int NUM_SRC = 2;

  typedef struct packed {
    logic                       valid;
    logic [NUM_SRC-1:0][AW-1:0] addr;
    logic [NUM_SRC-1:0]         rd;
    logic [AW-1:0]              wr_addr;
    logic                       we;
    logic                       is_load;
  } ex_req_t;

  ex_req_t id_req, ex_q;
  logic [NUM_SRC-1:0][DW-1:0] rf_data, op;
  logic          lw_vld;
  logic [AW-1:0] lw_addr;
  logic [DW-1:0] lw_data;
  logic          raw;

  // Pack the ID-stage instruction; index 0 is source a, 1 is source b.
  always_comb begin
    id_req         = '0;
    id_req.valid   = bus.id_valid;
    id_req.addr    = {bus.id_addrb, bus.id_addra};
    id_req.rd      = {bus.id_rdb, bus.id_rda};
    id_req.wr_addr = bus.id_wr_addr;
    id_req.we      = bus.id_we;
    id_req.is_load = bus.id_is_load;
  end

  // ID->EXE register; ID freeze with EXE running inserts a bubble; flush wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q <= '0;
    end else begin
      if (!bus.id_freeze)      ex_q       <= id_req;
      else if (!bus.ex_freeze) ex_q.valid <= 1'b0;
      if (bus.flushpipe)       ex_q.valid <= 1'b0;
    end
  end

`ifdef PIPPO_OPERAND_FWD_EN
  // Last write seen by the GPR file, covering a write on the same edge as the read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lw_vld  <= 1'b0;
      lw_addr <= '0;
      lw_data <= '0;
    end else if (bus.wb_we && !bus.flushpipe) begin
      lw_vld  <= 1'b1;
      lw_addr <= bus.wb_addr;
      lw_data <= bus.wb_data;
    end else begin
      lw_vld  <= 1'b0;
    end
  end
`else
  assign lw_vld  = 1'b0;
  assign lw_addr = '0;
  assign lw_data = '0;
`endif

  assign rf_data = {bus.rf_datab, bus.rf_dataa};

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    operand_fwd_src #(.DW(DW), .AW(AW)) u_src (
      .clk       (clk),
      .rst       (rst),
      .flushpipe (bus.flushpipe),
      .ex_freeze (bus.ex_freeze),
      .addr      (ex_q.addr[i]),
      .rd        (ex_q.rd[i]),
      .rf_data   (rf_data[i]),
      .wb_we     (bus.wb_we),
      .wb_addr   (bus.wb_addr),
      .wb_data   (bus.wb_data),
      .lw_vld    (lw_vld),
      .lw_addr   (lw_addr),
      .lw_data   (lw_data),
      .op        (op[i])
    );
  end

  assign bus.ex_opa   = op[0];
  assign bus.ex_opb   = op[1];
  assign bus.ex_valid = ex_q.valid;

  // RAW on a writing EXE instruction; with forwarding only loads must stall.
  always_comb begin
    raw = bus.id_valid && ex_q.valid && ex_q.we && (ex_q.wr_addr != '0) &&
          ((bus.id_rda && (bus.id_addra == ex_q.wr_addr)) ||
           (bus.id_rdb && (bus.id_addrb == ex_q.wr_addr)));
`ifdef PIPPO_OPERAND_FWD_EN
    bus.hazard_stall = raw && ex_q.is_load;
`else
    bus.hazard_stall = raw;
`endif
  end
endmodule

// File: doc/operand_fwd.md
OPERAND_FWD -- requirements
Module: operand_fwd

Interface
REQ-001 Parameter DW, default 64, operand width.
REQ-002 Parameter AW, default 5, GPR address width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 id_freeze, ex_freeze, flushpipe  in  1 each  pipeline controls.
REQ-006 id_valid  in  1  ID holds a valid instruction.
REQ-007 id_addra, id_addrb  in  AW  source addresses presented to the GPR file this cycle.
REQ-008 id_rda, id_rdb  in  1  source read enables.
REQ-009 id_wr_addr  in  AW; id_we  in  1; id_is_load  in  1  destination info of the ID instruction.
REQ-010 rf_dataa, rf_datab  in  DW  GPR read data; valid in the cycle after ID presents its addresses (EXE cycle).
REQ-011 wb_addr  in  AW; wb_data  in  DW; wb_we  in  1  writeback port, the same values driven to the GPR write port.
REQ-012 ex_opa, ex_opb  out  DW  resolved EXE operands.
REQ-013 ex_valid  out  1  EXE holds a valid instruction.
REQ-014 hazard_stall  out  1  request to freeze ID (combinational).

Function
REQ-015 On a clock edge with !id_freeze, the block SHALL register id_valid, id_addra/b, id_rda/b, id_wr_addr, id_we and id_is_load into EXE-stage registers; with id_freeze asserted these registers SHALL hold.
REQ-016 An ID->EXE transfer with id_freeze=1 and ex_freeze=0 SHALL load ex_valid=0 (bubble).
REQ-017 Operand select priority per source (a and b independently): hold register if its valid bit is set; else wb_data if wb_we & (wb_addr==ex_addr) & ex_rd; else last-write register if its valid bit is set & addr match; else rf_data.
REQ-018 Last-write register SHALL capture {1,wb_addr,wb_data} every edge with wb_we, and clear its valid bit on edges without wb_we; this covers a write landing in the same edge as the GPR read.
REQ-019 Address 0 SHALL NOT be forwarded; rf_data SHALL be used.
REQ-020 On the first edge with ex_freeze=1 while the hold valid bit is clear, the resolved operand SHALL be captured into the hold register with valid=1; while frozen the value SHALL not change; the first edge with ex_freeze=0 SHALL clear the valid bit.
REQ-021 ex_opa/ex_opb SHALL be zero when the corresponding ex_rd is 0.
REQ-022 hazard_stall SHALL be 1 when ex_valid & ex_is_load & ex_we & id_valid & ((id_rda & id_addra==ex_wr_addr) | (id_rdb & id_addrb==ex_wr_addr)) & ex_wr_addr!=0.
REQ-023 flushpipe SHALL clear ex_valid, both hold valid bits and the last-write valid bit on the next edge; flushpipe takes priority over freeze.
REQ-024 Simultaneous flushpipe and wb_we: the write still reaches the GPR file, but it SHALL NOT be recorded in the last-write register.

Reset
REQ-025 While rst=0, all EXE-stage registers, hold registers and the last-write register SHALL clear asynchronously.
REQ-026 The outputs SHALL read ex_valid=0, ex_opa=ex_opb=0 and hazard_stall=0 during reset and on the first cycle after release.

Configuration
REQ-027 Macro PIPPO_OPERAND_FWD_EN: when defined, REQ-017/018 forwarding SHALL apply.
REQ-028 When PIPPO_OPERAND_FWD_EN is undefined, operands SHALL come from the hold register or rf_data only, and hazard_stall SHALL assert for any RAW match against a valid EXE instruction with ex_we, load or not.

Verification
REQ-029 Reset: drive rst=0 mid-freeze with hold valid set -> ex_valid=0, ex_opa=0 immediately, with no clock edge.
REQ-030 WB forward: EXE reads r3, rf_dataa=0x11, wb_we=1 to r3 with 0xAA -> ex_opa=0xAA in the same cycle.
REQ-031 Last-write: write r5=0x55 on the same edge the ID reads r5, then rf_datab=stale 0x0 -> ex_opb=0x55.
REQ-032 Freeze hold: ex_freeze=1 for 3 cycles, ex_opa=0x1234, then a WB write to the same register with 0x9999 -> ex_opa stays 0x1234 until the cycle after release.
REQ-033 Load-use: EXE is a load to r7, ID reads r7 -> hazard_stall=1; the same case with r0 -> hazard_stall=0.
REQ-034 Flush: flushpipe together with ex_freeze and wb_we -> next cycle ex_valid=0, hold and last-write valid bits cleared.
